// File: rtl/sr_latch_ctrl.sv
// Sequencer for a bank of gated SR latches: arbitrates two requesters, then
// drives setup / enable pulse / hold, reads the latch back and acknowledges.
module sr_latch_ctrl #(
   parameter int unsigned N         = 4,
   parameter int unsigned PULSE_CYC = 2,
   localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_op,
   input  logic [IW-1:0] a_idx,
   input  logic          b_req,
   input  logic          b_op,
   input  logic [IW-1:0] b_idx,
   output logic          a_ack,
   output logic          b_ack,
   output logic          err,
   output logic [N-1:0]  S,
   output logic [N-1:0]  R,
   output logic [N-1:0]  E,
   input  logic [N-1:0]  Q
);

   localparam int unsigned CW = 4;

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

   state_t        state;
   logic          op_q;
   logic [IW-1:0] idx_q;
   logic          gnt_b;
   logic          rr_b;
   logic [CW-1:0] cnt;

   logic          grant_a_c;
   logic          grant_b_c;
   logic          g_op_c;
   logic [IW-1:0] g_idx_c;
   logic [N-1:0]  g_sel_c;
   logic [N-1:0]  sel_c;
   logic          q_sel_c;
   logic          idx_ok_c;

   // Round-robin grant: rr_b set means B wins a tie.
   always_comb begin
      grant_a_c = a_req & (~b_req | ~rr_b);
      grant_b_c = b_req & ~grant_a_c;
      g_op_c    = grant_b_c ? b_op  : a_op;
      g_idx_c   = grant_b_c ? b_idx : a_idx;
   end

   // One-hot decode of the incoming and the registered index; out-of-range gives zero.
   always_comb begin
      g_sel_c = '0;
      sel_c   = '0;
      q_sel_c = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (IW'(i) == g_idx_c) g_sel_c[i] = 1'b1;
         if (IW'(i) == idx_q) begin
            sel_c[i] = 1'b1;
            q_sel_c  = Q[i];
         end
      end
      idx_ok_c = |sel_c;
   end

   // Sequencer; outputs are loaded for the state being entered so they are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         op_q  <= 1'b0;
         idx_q <= '0;
         gnt_b <= 1'b0;
         rr_b  <= 1'b0;
         cnt   <= '0;
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         err   <= 1'b0;
         S     <= '0;
         R     <= '0;
         E     <= '0;
      end else begin
         a_ack <= 1'b0;
         b_ack <= 1'b0;
         err   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_a_c || grant_b_c) begin
                  state <= SETUP;
                  op_q  <= g_op_c;
                  idx_q <= g_idx_c;
                  gnt_b <= grant_b_c;
                  rr_b  <= grant_a_c;
                  S     <= g_op_c ? g_sel_c : '0;
                  R     <= g_op_c ? '0 : g_sel_c;
                  E     <= '0;
               end
            end
            SETUP: begin
               state <= PULSE;
               E     <= sel_c;
               cnt   <= CW'(PULSE_CYC - 1);
            end
            PULSE: begin
               if (cnt == '0) begin
                  state <= HOLD;
                  E     <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            HOLD: begin
               // Q is stable with the gate closed; sample it here so ack/err land in CHECK.
               state <= CHECK;
               S     <= '0;
               R     <= '0;
               E     <= '0;
               a_ack <= ~gnt_b;
               b_ack <= gnt_b;
               err   <= ~idx_ok_c | (q_sel_c != op_q);
            end
            CHECK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               S     <= '0;
               R     <= '0;
               E     <= '0;
            end
         endcase
      end
   end

endmodule
